// File: rtl/seg_char_pkg.sv
// seg_char_pkg: character codes and active-low 7-segment patterns {g,f,e,d,c,b,a}
package seg_char_pkg;
   localparam int CHAR_W = 5;
   localparam logic [CHAR_W-1:0] CHAR_BLANK = 5'd16;
   localparam logic [CHAR_W-1:0] CHAR_T     = 5'd17;
   localparam logic [CHAR_W-1:0] CHAR_J     = 5'd18;
   localparam logic [CHAR_W-1:0] CHAR_DASH  = 5'd19;
   localparam logic [CHAR_W-1:0] CHAR_H     = 5'd20;
   localparam logic [CHAR_W-1:0] CHAR_L     = 5'd21;
   localparam logic [CHAR_W-1:0] CHAR_P     = 5'd22;
   localparam logic [CHAR_W-1:0] CHAR_U     = 5'd23;
   localparam logic [CHAR_W-1:0] CHAR_R     = 5'd24;
   localparam logic [CHAR_W-1:0] CHAR_N     = 5'd25;
   localparam logic [CHAR_W-1:0] CHAR_O     = 5'd26;

   function automatic logic [6:0] seg_decode(input logic [CHAR_W-1:0] code);
      case (code)
         5'd0:      seg_decode = 7'b1000000;
         5'd1:      seg_decode = 7'b1111001;
         5'd2:      seg_decode = 7'b0100100;
         5'd3:      seg_decode = 7'b0110000;
         5'd4:      seg_decode = 7'b0011001;
         5'd5:      seg_decode = 7'b0010010;
         5'd6:      seg_decode = 7'b0000010;
         5'd7:      seg_decode = 7'b1111000;
         5'd8:      seg_decode = 7'b0000000;
         5'd9:      seg_decode = 7'b0010000;
         5'd10:     seg_decode = 7'b0001000;
         5'd11:     seg_decode = 7'b0000011;
         5'd12:     seg_decode = 7'b1000110;
         5'd13:     seg_decode = 7'b0100001;
         5'd14:     seg_decode = 7'b0000110;
         5'd15:     seg_decode = 7'b0001110;
         CHAR_T:    seg_decode = 7'b0000111;
         CHAR_J:    seg_decode = 7'b1110001;
         CHAR_DASH: seg_decode = 7'b0111111;
         CHAR_H:    seg_decode = 7'b0001001;
         CHAR_L:    seg_decode = 7'b1000111;
         CHAR_P:    seg_decode = 7'b0001100;
         CHAR_U:    seg_decode = 7'b1000001;
         CHAR_R:    seg_decode = 7'b0101111;
         CHAR_N:    seg_decode = 7'b0101011;
         CHAR_O:    seg_decode = 7'b0100011;
         default:   seg_decode = 7'b1111111;
      endcase
   endfunction
endpackage

// File: rtl/seg_multi_char_display_if.sv
// seg_multi_char_display_if: content update handshake between control FSM and display driver
interface seg_multi_char_display_if #(parameter int NUM_DIGITS = 4);
   import seg_char_pkg::*;
   logic                           upd_valid;
   logic                           upd_ready;
   logic [CHAR_W*NUM_DIGITS-1:0]   upd_chars;
   logic [NUM_DIGITS-1:0]          upd_dp;
   logic [NUM_DIGITS-1:0]          upd_blink;
   modport master(output upd_valid, upd_chars, upd_dp, upd_blink, input upd_ready);
   modport slave(input upd_valid, upd_chars, upd_dp, upd_blink, output upd_ready);
endinterface

// File: rtl/seg_char_decoder.sv
// seg_char_decoder: combinational 5-bit character code to active-low 7-segment pattern
module seg_char_decoder
   import seg_char_pkg::*;
(
   input  logic [CHAR_W-1:0] code,
   output logic [6:0]        seg_n
);
   assign seg_n = seg_decode(code);
endmodule

// File: rtl/seg_multi_char_display.sv
// seg_multi_char_display: multiplexed N-digit 7-segment driver with frame-synchronous updates.
// Optional per-digit blink enabled by defining SEG_BLINK_EN.
module seg_multi_char_display
   import seg_char_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 25000,
   parameter int BLANK_CYCLES = 8,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   seg_multi_char_display_if.slave upd,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  frame_done
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = CHAR_W * NUM_DIGITS;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < BLANK_CYCLES + 2 || BLINK_FRAMES < 1) begin : g_bad_cfg
      $error("seg_multi_char_display: invalid parameter combination");
   end

   logic [CW-1:0]         scan_cnt;
   logic [IW-1:0]         digit_idx;
   logic [0:0]            state;
   logic [DW-1:0]         shd_chars, disp_chars;
   logic [NUM_DIGITS-1:0] shd_dp, disp_dp;
   logic                  slot_end, wrap, accept, commit, blanking, blank_dig;
   logic [CHAR_W-1:0]     cur_char;
   logic [6:0]            dig_seg;

   assign slot_end      = scan_cnt == CW'(SCAN_DIV - 1);
   assign wrap          = slot_end && digit_idx == IW'(NUM_DIGITS - 1);
   assign accept        = state == ST_IDLE && upd.upd_valid;
   assign commit        = state == ST_PEND && wrap;
   assign upd.upd_ready = state == ST_IDLE;
   assign blanking      = scan_cnt < CW'(BLANK_CYCLES);
   assign cur_char      = disp_chars[CHAR_W*digit_idx +: CHAR_W];

   seg_char_decoder u_dec (.code(cur_char), .seg_n(dig_seg));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt   <= '0;
         digit_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         scan_cnt   <= slot_end ? '0 : scan_cnt + 1'b1;
         digit_idx  <= wrap ? '0 : slot_end ? digit_idx + 1'b1 : digit_idx;
         frame_done <= wrap;
      end
   end

   // Shadow buffer only reaches the display at a wrap, so a frame never mixes old and new digits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         shd_chars  <= {NUM_DIGITS{CHAR_BLANK}};
         shd_dp     <= '0;
         disp_chars <= {NUM_DIGITS{CHAR_BLANK}};
         disp_dp    <= '0;
      end else if (accept) begin
         state     <= ST_PEND;
         shd_chars <= upd.upd_chars;
         shd_dp    <= upd.upd_dp;
      end else if (commit) begin
         state      <= ST_IDLE;
         disp_chars <= shd_chars;
         disp_dp    <= shd_dp;
      end
   end

`ifdef SEG_BLINK_EN
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [BW-1:0]         blink_cnt;
   logic                  phase, blink_last;
   logic [NUM_DIGITS-1:0] shd_blink, disp_blink;
   assign blink_last = blink_cnt == BW'(BLINK_FRAMES - 1);
   assign blank_dig  = phase && disp_blink[digit_idx];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt  <= '0;
         phase      <= 1'b0;
         shd_blink  <= '0;
         disp_blink <= '0;
      end else begin
         shd_blink  <= accept ? upd.upd_blink : shd_blink;
         disp_blink <= commit ? shd_blink : disp_blink;
         blink_cnt  <= wrap ? (blink_last ? '0 : blink_cnt + 1'b1) : blink_cnt;
         phase      <= wrap && blink_last ? ~phase : phase;
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^upd.upd_blink;
   assign blank_dig    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= 8'hFF;
         an  <= '1;
      end else begin
         an  <= blanking ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
         seg <= blanking || blank_dig ? 8'hFF : {~disp_dp[digit_idx], dig_seg};
      end
   end
endmodule

// File: tb/tb_seg_multi_char_display.sv
// tb_seg_multi_char_display: table-driven scoreboard bench for the multiplexed 7-segment driver.
// Blink expectations follow SEG_BLINK_EN, matching the DUT build.
module tb_seg_multi_char_display;
   localparam int ND = 4, SD = 6, BC = 2, BF = 2, FRAME = ND * SD;

   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] seg;
   logic [ND-1:0] an;
   logic frame_done;

   seg_multi_char_display_if #(.NUM_DIGITS(ND)) upd_if();

   seg_multi_char_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .upd(upd_if), .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] chars;
      logic [3:0]  dp;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[7];
   logic [31:0] exp_q[$];
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!upd_if.upd_ready && n < 3 * FRAME);
      chk({name, " ready_return"}, upd_if.upd_ready, 1);
   endtask

   task automatic send(input logic [19:0] chars, input logic [3:0] dp, input logic [3:0] blink);
      chk("ready_before_send", upd_if.upd_ready, 1);
      upd_if.upd_valid = 1'b1;
      upd_if.upd_chars = chars;
      upd_if.upd_dp    = dp;
      upd_if.upd_blink = blink;
      @(posedge clk);
      #1;
      upd_if.upd_valid = 1'b0;
      upd_if.upd_chars = 20'($urandom);
      upd_if.upd_dp    = 4'($urandom);
      upd_if.upd_blink = 4'($urandom);
      @(negedge clk);
      chk("ready_drop", upd_if.upd_ready, 0);
   endtask

   // Starts on the negedge where the counters sit at digit 0, slot 0; outputs lag the counters by one cycle
   task automatic capture(input string name);
      logic [31:0] e;
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      int pos, d;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: got empty queue, expected a frame entry", name);
         return;
      end
      e = exp_q.pop_front();
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         pos     = (k - 1) % SD;
         d       = (k - 1) / SD;
         exp_an  = pos < BC ? 4'hF : ~(4'b0001 << d);
         exp_seg = pos < BC ? 8'hFF : e[8*d +: 8];
         chk({name, " an"}, an, exp_an);
         chk({name, " seg"}, seg, exp_seg);
         chk({name, " frame_done"}, frame_done, k == FRAME);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic blink_on;
      upd_if.upd_valid = 1'b0;
      upd_if.upd_chars = '0;
      upd_if.upd_dp    = '0;
      upd_if.upd_blink = '0;
      vecs[0] = '{chars: {5'd17, 5'd10, 5'd12, 5'd18}, dp: 4'b0000, exp: 32'h87_88_C6_F1};
      vecs[1] = '{chars: {5'd0, 5'd1, 5'd2, 5'd3},     dp: 4'b0101, exp: 32'hC0_79_A4_30};
      vecs[2] = '{chars: {5'd20, 5'd21, 5'd22, 5'd23}, dp: 4'b1000, exp: 32'h09_C7_8C_C1};
      vecs[3] = '{chars: {5'd24, 5'd25, 5'd26, 5'd19}, dp: 4'b0000, exp: 32'hAF_AB_A3_BF};
      vecs[4] = '{chars: {5'd14, 5'd15, 5'd16, 5'd31}, dp: 4'b0010, exp: 32'h86_8E_7F_FF};
      vecs[5] = '{chars: {5'd8, 5'd9, 5'd11, 5'd13},   dp: 4'b0000, exp: 32'h80_90_83_A1};
      vecs[6] = '{chars: {5'd4, 5'd5, 5'd6, 5'd7},     dp: 4'b0000, exp: 32'h99_92_82_F8};

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_seg", seg, 8'hFF);
         chk("rst_an", an, 4'hF);
         chk("rst_ready", upd_if.upd_ready, 1);
         chk("rst_frame_done", frame_done, 0);
      end
      rst = 1'b0;
      exp_q.push_back(32'hFFFF_FFFF);
      capture("reset_blank");

      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(vecs[i].exp);
         send(vecs[i].chars, vecs[i].dp, 4'b0000);
         if (i == 0) begin
            upd_if.upd_valid = 1'b1;
            upd_if.upd_chars = {4{5'd5}};
            upd_if.upd_dp    = 4'b0000;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk("pending_ready", upd_if.upd_ready, 0);
            end
            upd_if.upd_valid = 1'b0;
         end
         wait_ready($sformatf("vec%0d", i));
         capture($sformatf("vec%0d", i));
         if (i == 0) begin
            exp_q.push_back(32'h92_92_92_92);
            send({4{5'd5}}, 4'b0000, 4'b0000);
            wait_ready("late");
            capture("late_accept");
         end
      end

      send(vecs[1].chars, vecs[1].dp, 4'b0000);
      n = 0;
      while (an == 4'hF && n < FRAME) begin
         @(negedge clk);
         n++;
      end
      chk("midslot_lit", an != 4'hF, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_seg", seg, 8'hFF);
      chk("async_rst_an", an, 4'hF);
      chk("async_rst_ready", upd_if.upd_ready, 1);
      chk("async_rst_frame_done", frame_done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(32'hFFFF_FFFF);
      capture("post_reset_blank");
      chk("post_reset_ready", upd_if.upd_ready, 1);

      for (int f = 2; f < 8; f++) begin
`ifdef SEG_BLINK_EN
         blink_on = ((f / BF) % 2) == 1;
`else
         blink_on = 1'b0;
`endif
         exp_q.push_back({24'h87_88_C6, blink_on ? 8'hFF : 8'hF1});
      end
      send(vecs[0].chars, 4'b0000, 4'b0001);
      wait_ready("blink");
      for (int f = 2; f < 8; f++) capture($sformatf("blink_frame%0d", f));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
